// File: rtl/drp_bridge_if.sv
// Bus bundle for drp_bridge: command/response handshake toward the requester
// plus the DRP port toward the target. slave = bridge view, master = environment view.
interface drp_bridge_if #(
    parameter int ADDR_W = 32
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [15:0]       cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_rdata;
    logic              rsp_err;
    logic              drp_en;
    logic              drp_we;
    logic [ADDR_W-1:0] drp_addr;
    logic [15:0]       drp_di;
    logic [15:0]       drp_do;
    logic              drp_rdy;

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, drp_do, drp_rdy,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, drp_en, drp_we, drp_addr, drp_di
    );

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, drp_do, drp_rdy,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, drp_en, drp_we, drp_addr, drp_di
    );
endinterface

// File: rtl/drp_bridge.sv
// Single-outstanding command/response to DRP bridge with a WAIT-state timeout
// and a saturating count of aborted transactions. All outputs are registered.
module drp_bridge #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    drp_bridge_if.slave      bus,
    output logic             busy,
    output logic [7:0]       timeout_cnt
);
    localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [15:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              drp_en_q, drp_en_d;
    logic              drp_we_q, drp_we_d;
    logic [ADDR_W-1:0] drp_addr_q, drp_addr_d;
    logic [15:0]       drp_di_q, drp_di_d;
    logic              busy_q, busy_d;
    logic [7:0]        tmo_q, tmo_d;
    logic [15:0]       wait_cnt_q, wait_cnt_d;
    logic [15:0]       wait_cnt_inc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; no memories here, so everything is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            drp_en_q    <= 1'b0;
            drp_we_q    <= 1'b0;
            drp_addr_q  <= '0;
            drp_di_q    <= '0;
            busy_q      <= 1'b0;
            tmo_q       <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            drp_en_q    <= drp_en_d;
            drp_we_q    <= drp_we_d;
            drp_addr_q  <= drp_addr_d;
            drp_di_q    <= drp_di_d;
            busy_q      <= busy_d;
            tmo_q       <= tmo_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        drp_en_d     = 1'b0;
        drp_we_d     = drp_we_q;
        drp_addr_d   = drp_addr_q;
        drp_di_d     = drp_di_q;
        busy_d       = busy_q;
        tmo_d        = tmo_q;
        wait_cnt_d   = wait_cnt_q;
        wait_cnt_inc = wait_cnt_q + 16'd1;

        unique case (state_q)
            IDLE: begin
                // cmd_ready_q is still 0 on the first edge after reset release
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d     = ISSUE;
                    cmd_ready_d = 1'b0;
                    drp_en_d    = 1'b1;
                    drp_we_d    = bus.cmd_we;
                    drp_addr_d  = bus.cmd_addr;
                    drp_di_d    = bus.cmd_wdata;
                    busy_d      = 1'b1;
                end
            end
            ISSUE: begin
                state_d    = WAIT;
                wait_cnt_d = '0;
            end
            WAIT: begin
                // drp_rdy wins over a timeout landing on the same edge
                if (bus.drp_rdy) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = drp_we_q ? 16'h0000 : bus.drp_do;
                    rsp_err_d   = 1'b0;
                end else if (wait_cnt_inc == TIMEOUT_V) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 16'h0000;
                    rsp_err_d   = 1'b1;
                    if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    drp_we_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.drp_en    = drp_en_q;
    assign bus.drp_we    = drp_we_q;
    assign bus.drp_addr  = drp_addr_q;
    assign bus.drp_di    = drp_di_q;
    assign busy          = busy_q;
    assign timeout_cnt   = tmo_q;
endmodule

// File: tb/tb_drp_bridge.sv
// Directed bench for drp_bridge (TIMEOUT=8): write, read, timeout, boundary,
// backpressure, reset-in-WAIT and timeout counter saturation.
module tb_drp_bridge;
    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [7:0] timeout_cnt;
    int         checks;
    int         errors;
    int         en_count;
    int         en_snap;
    logic [15:0] rd;
    logic        er;

    drp_bridge_if #(.ADDR_W(32)) bus ();

    drp_bridge #(.ADDR_W(32), .TIMEOUT(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .timeout_cnt (timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.drp_en === 1'b1) en_count <= en_count + 1;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one command and consumes its response; rdy_after<0 means no drp_rdy.
    task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [15:0] wdata,
                           input int rdy_after, input logic [15:0] dval,
                           output logic [15:0] rdata, output logic err);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        tick();
        bus.cmd_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.rsp_valid === 1'b1) break;
            bus.drp_rdy = (n == rdy_after);
            bus.drp_do  = dval;
            tick();
        end
        bus.drp_rdy = 1'b0;
        check("rsp_seen", bus.rsp_valid, 1);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; en_count = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0; bus.drp_do = '0; bus.drp_rdy = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_drp_en", bus.drp_en, 0);
        check("rst_busy", busy, 0);
        check("rst_tmo", timeout_cnt, 0);
        rst_n = 1'b1;
        tick();
        check("rel_cmd_ready", bus.cmd_ready, 1);
        check("rel_busy", busy, 0);

        // Write, drp_rdy three cycles after drp_en
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_addr = 32'h0000_007C; bus.cmd_wdata = 16'hA5A5;
        tick();
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_wdata = '0;
        check("wr_drp_en", bus.drp_en, 1);
        check("wr_drp_we", bus.drp_we, 1);
        check("wr_drp_addr", bus.drp_addr, 32'h7C);
        check("wr_drp_di", bus.drp_di, 16'hA5A5);
        check("wr_cmd_ready", bus.cmd_ready, 0);
        check("wr_busy", busy, 1);
        tick();
        check("wr_en_pulse", bus.drp_en, 0);
        check("wr_di_hold", bus.drp_di, 16'hA5A5);
        repeat (2) tick();
        bus.drp_rdy = 1'b1; bus.drp_do = 16'hFFFF;
        tick();
        bus.drp_rdy = 1'b0;
        check("wr_rsp_valid", bus.rsp_valid, 1);
        check("wr_rdata", bus.rsp_rdata, 0);
        check("wr_err", bus.rsp_err, 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("wr_done_valid", bus.rsp_valid, 0);
        check("wr_done_ready", bus.cmd_ready, 1);
        check("wr_done_we", bus.drp_we, 0);
        check("wr_en_count", en_count, 1);

        // Read
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 32'h0000_0011;
        tick();
        bus.cmd_valid = 1'b0;
        check("rd_drp_addr", bus.drp_addr, 32'h11);
        check("rd_drp_we", bus.drp_we, 0);
        tick();
        bus.drp_rdy = 1'b1; bus.drp_do = 16'h1234;
        check("rd_pre_valid", bus.rsp_valid, 0);
        tick();
        bus.drp_rdy = 1'b0; bus.drp_do = 16'h0000;
        check("rd_rsp_valid", bus.rsp_valid, 1);
        check("rd_rdata", bus.rsp_rdata, 16'h1234);
        check("rd_err", bus.rsp_err, 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // drp_rdy pulse while idle
        bus.drp_rdy = 1'b1; bus.drp_do = 16'hDEAD;
        tick();
        bus.drp_rdy = 1'b0;
        check("idle_rdy_valid", bus.rsp_valid, 0);
        check("idle_rdy_busy", busy, 0);
        check("idle_rdy_ready", bus.cmd_ready, 1);
        check("idle_rdy_rdata", bus.rsp_rdata, 16'h1234);
        tick();
        check("idle_rdy_valid2", bus.rsp_valid, 0);

        // Timeout after 8 WAIT cycles
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 32'h20;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (8) tick();
        check("to_not_yet", bus.rsp_valid, 0);
        check("to_busy", busy, 1);
        tick();
        check("to_valid", bus.rsp_valid, 1);
        check("to_err", bus.rsp_err, 1);
        check("to_rdata", bus.rsp_rdata, 0);
        check("to_cnt", timeout_cnt, 1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // drp_rdy on the timeout edge wins
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 32'h24;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (8) tick();
        bus.drp_rdy = 1'b1; bus.drp_do = 16'hBEEF;
        tick();
        bus.drp_rdy = 1'b0;
        check("bnd_valid", bus.rsp_valid, 1);
        check("bnd_err", bus.rsp_err, 0);
        check("bnd_rdata", bus.rsp_rdata, 16'hBEEF);
        check("bnd_cnt", timeout_cnt, 1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Backpressure with a second command held
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_addr = 32'h40; bus.cmd_wdata = 16'h5A5A;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.drp_rdy = 1'b1;
        tick();
        bus.drp_rdy = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 32'h80;
        en_snap = en_count;
        for (int i = 0; i < 10; i++) begin
            bus.drp_do = 16'h7777;
            tick();
            check("bp_valid", bus.rsp_valid, 1);
            check("bp_rdata", bus.rsp_rdata, 0);
            check("bp_err", bus.rsp_err, 0);
            check("bp_cmd_ready", bus.cmd_ready, 0);
            check("bp_drp_en", bus.drp_en, 0);
        end
        check("bp_no_issue", en_count, en_snap);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("bp_rel_valid", bus.rsp_valid, 0);
        check("bp_rel_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        check("bp_2nd_en", bus.drp_en, 1);
        check("bp_2nd_addr", bus.drp_addr, 32'h80);
        check("bp_2nd_we", bus.drp_we, 0);
        tick();
        bus.drp_rdy = 1'b1; bus.drp_do = 16'h4321;
        tick();
        bus.drp_rdy = 1'b0;
        check("bp_2nd_rdata", bus.rsp_rdata, 16'h4321);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Reset while in WAIT
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_addr = 32'h99; bus.cmd_wdata = 16'h1111;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rw_busy", busy, 0);
        check("rw_drp_we", bus.drp_we, 0);
        check("rw_drp_addr", bus.drp_addr, 0);
        check("rw_drp_di", bus.drp_di, 0);
        check("rw_rdata", bus.rsp_rdata, 0);
        check("rw_cmd_ready", bus.cmd_ready, 0);
        check("rw_tmo", timeout_cnt, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("rw_rel_ready", bus.cmd_ready, 1);
        bus.drp_rdy = 1'b1; bus.drp_do = 16'hAAAA;
        tick();
        bus.drp_rdy = 1'b0;
        check("rw_late_rdy_valid", bus.rsp_valid, 0);
        check("rw_late_rdy_busy", busy, 0);
        run_cmd(1'b0, 32'h55, 16'h0, 2, 16'h0F0F, rd, er);
        check("rw_next_rdata", rd, 16'h0F0F);
        check("rw_next_err", er, 0);

        // 300 timeouts saturate the counter at 255
        for (int i = 0; i < 300; i++) begin
            run_cmd(1'b0, 32'(i), 16'h0, -1, 16'h0, rd, er);
            if (i == 0)   check("sat_first", timeout_cnt, 1);
            if (i == 254) check("sat_255", timeout_cnt, 255);
        end
        check("sat_err", er, 1);
        check("sat_final", timeout_cnt, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/drp_bridge.md
DRP_BRIDGE -- requirements
Module: drp_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, DRP address width.
REQ-002 SHALL have parameter TIMEOUT, default 1023, maximum WAIT cycles before a transaction is aborted; legal range 1..65535.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port cmd_valid  in  1  command request.
REQ-006 SHALL have port cmd_ready  out  1  bridge accepts a command.
REQ-007 SHALL have port cmd_we  in  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr  in  ADDR_W  DRP target address.
REQ-009 SHALL have port cmd_wdata  in  16  write data.
REQ-010 SHALL have port rsp_valid  out  1  response available.
REQ-011 SHALL have port rsp_ready  in  1  response consumed.
REQ-012 SHALL have port rsp_rdata  out  16  read data; 0 for writes.
REQ-013 SHALL have port rsp_err  out  1  transaction timed out.
REQ-014 SHALL have port drp_en  out  1  DRP enable strobe.
REQ-015 SHALL have port drp_we  out  1  DRP write enable.
REQ-016 SHALL have port drp_addr  out  ADDR_W  DRP address.
REQ-017 SHALL have port drp_di  out  16  DRP write data.
REQ-018 SHALL have port drp_do  in  16  DRP read data, valid with drp_rdy.
REQ-019 SHALL have port drp_rdy  in  1  DRP completion.
REQ-020 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-021 SHALL have port timeout_cnt  out  8  saturating count of timed-out transactions.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-023 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on an edge where cmd_valid&&cmd_ready.
REQ-024 SHALL on acceptance latch cmd_we/cmd_addr/cmd_wdata into drp_we/drp_addr/drp_di and move IDLE->ISSUE.
REQ-025 SHALL assert drp_en for exactly one cycle (ISSUE), then move ISSUE->WAIT unconditionally.
REQ-026 SHALL hold drp_addr/drp_we/drp_di stable from ISSUE until return to IDLE; drp_we SHALL be 0 outside ISSUE/WAIT/RESP.
REQ-027 SHALL sample drp_rdy only in WAIT; drp_rdy in IDLE, ISSUE or RESP is ignored with no state or output change.
REQ-028 SHALL in WAIT on drp_rdy=1: rsp_rdata<=drp_do for reads, 0 for writes; rsp_err<=0; move to RESP.
REQ-029 SHALL count WAIT cycles with a 16-bit counter cleared on entry to WAIT; if counter reaches TIMEOUT with drp_rdy=0: rsp_err<=1, rsp_rdata<=16'h0000, timeout_cnt+=1 (saturate at 255), move to RESP.
REQ-030 SHALL give drp_rdy priority when drp_rdy=1 on the same edge the counter reaches TIMEOUT (success, no error).
REQ-031 SHALL assert rsp_valid in RESP and hold rsp_rdata/rsp_err stable until rsp_valid&&rsp_ready, then move RESP->IDLE and clear rsp_valid.
REQ-032 SHALL yield latency: drp_en one cycle after acceptance; rsp_valid one cycle after sampled drp_rdy; minimum 4 cycles per transaction, no command overlap.
REQ-033 SHALL never assert drp_en while a transaction is in WAIT or RESP.

Reset
REQ-034 SHALL on rst_n=0 immediately force state=IDLE, cmd_ready=0 while reset asserted, rsp_valid=0, rsp_err=0, rsp_rdata=0, drp_en=0, drp_we=0, drp_addr=0, drp_di=0, busy=0, timeout_cnt=0, wait counter=0.
REQ-035 SHALL after rst_n release enter IDLE with cmd_ready=1 on the first edge.
REQ-036 SHALL abandon any in-flight transaction on reset without a response; a drp_rdy arriving after reset release in IDLE is ignored.

Verification
REQ-037 SHALL cover write: cmd addr=0x0000_007C, wdata=0xA5A5, we=1, drp_rdy 3 cycles after drp_en -> one drp_en pulse, drp_di=0xA5A5, rsp_valid with rsp_rdata=0, rsp_err=0.
REQ-038 SHALL cover read: addr=0x0000_0011, drp_rdy with drp_do=0x1234 -> rsp_rdata=0x1234, rsp_err=0, rsp_valid one cycle after drp_rdy.
REQ-039 SHALL cover timeout: TIMEOUT=8, no drp_rdy -> rsp_err=1, rsp_rdata=0 after 8 WAIT cycles, timeout_cnt=1; 300 timeouts -> timeout_cnt=255.
REQ-040 SHALL cover backpressure: rsp_ready=0 for 10 cycles, second cmd_valid held -> rsp stable, cmd_ready=0, no drp_en until response consumed.
REQ-041 SHALL cover boundary: drp_rdy on the TIMEOUT edge -> success; drp_rdy pulse in IDLE -> no response, no state change.
REQ-042 SHALL cover reset in WAIT: rst_n low 2 cycles -> all outputs zero immediately, no rsp_valid, later drp_rdy ignored, next command completes normally.
